// File: rtl/alu_serial_issue_if.sv
// Request/response bundle for the nibble-serial ALU.
// slave: the ALU side; master: the issuing controller side.
interface alu_serial_issue_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_opt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_carry;
    logic             out_overflow;
    logic             out_zero;
    logic             out_less;
    logic             out_equal;

    modport slave (
        input  in_valid, in_a, in_b, in_opt, out_ready,
        output in_ready, out_valid, out_result,
               out_carry, out_overflow, out_zero, out_less, out_equal
    );

    modport master (
        output in_valid, in_a, in_b, in_opt, out_ready,
        input  in_ready, out_valid, out_result,
               out_carry, out_overflow, out_zero, out_less, out_equal
    );
endinterface

// File: rtl/alu_serial_issue.sv
// Multi-cycle signed ALU: processes WIDTH-bit operands one nibble per
// cycle, LSB first, with a carry register chaining the nibbles.
module alu_serial_issue #(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               rst_n,
    alu_serial_issue_if.slave bus
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_LT  = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [2:0]       opt_q, opt_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d;
    logic             less_q, less_d, equal_q, equal_d;

    logic [3:0] a_nib, b_nib, b_eff, r_nib;
    logic [4:0] sum;
    logic       is_sub, is_arith, ovf_add, ovf_sub, res_zero;

    // Next-state, per-nibble datapath and flag evaluation on the last nibble
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        opt_d   = opt_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        res_d   = res_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        less_d  = less_q;
        equal_d = equal_q;

        is_sub   = (opt_q == OP_SUB) || (opt_q == OP_LT) || (opt_q == OP_EQ);
        is_arith = is_sub || (opt_q == OP_ADD);
        a_nib    = a_q[{cnt_q, 2'b00} +: 4];
        b_nib    = b_q[{cnt_q, 2'b00} +: 4];
        b_eff    = is_sub ? ~b_nib : b_nib;
        sum      = {1'b0, a_nib} + {1'b0, b_eff} + {4'b0000, c_q};

        case (opt_q)
            OP_NOT:  r_nib = ~a_nib;
            OP_AND:  r_nib = a_nib & b_nib;
            OP_OR:   r_nib = a_nib | b_nib;
            OP_XOR:  r_nib = a_nib ^ b_nib;
            default: r_nib = sum[3:0];
        endcase

        ovf_add  = 1'b0;
        ovf_sub  = 1'b0;
        res_zero = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    opt_d   = bus.in_opt;
                    cnt_d   = '0;
                    c_d     = (bus.in_opt == OP_SUB) || (bus.in_opt == OP_LT) ||
                              (bus.in_opt == OP_EQ);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                res_d[{cnt_q, 2'b00} +: 4] = r_nib;
                c_d = is_arith ? sum[4] : 1'b0;
                // Flags are evaluated from the fully assembled result,
                // i.e. including the nibble written on this same edge.
                if (cnt_q == LAST) begin
                    ovf_add  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
                    ovf_sub  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
                    res_zero = (res_d == '0);
                    carry_d  = is_arith ? sum[4] : 1'b0;
                    ovf_d    = (opt_q == OP_ADD) ? ovf_add : (is_sub ? ovf_sub : 1'b0);
                    zero_d   = (opt_q == OP_EQ) ? 1'b0 : res_zero;
                    less_d   = (opt_q == OP_LT) ? (ovf_sub ^ res_d[WIDTH-1]) : 1'b0;
                    equal_d  = (opt_q == OP_EQ) ? res_zero : 1'b0;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, operand, result and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            opt_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            res_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            less_q  <= 1'b0;
            equal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            opt_q   <= opt_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            less_q  <= less_d;
            equal_q <= equal_d;
        end
    end

    assign bus.in_ready     = (state_q == IDLE);
    assign bus.out_valid    = (state_q == DONE);
    assign bus.out_result   = res_q;
    assign bus.out_carry    = carry_q;
    assign bus.out_overflow = ovf_q;
    assign bus.out_zero     = zero_q;
    assign bus.out_less     = less_q;
    assign bus.out_equal    = equal_q;
endmodule

// File: tb/tb_alu_serial_issue.sv
// Directed bench for alu_serial_issue at WIDTH = 4, 8 and 16.
module tb_alu_serial_issue;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_serial_issue_if #(.WIDTH(4))  if4  ();
    alu_serial_issue_if #(.WIDTH(8))  if8  ();
    alu_serial_issue_if #(.WIDTH(16)) if16 ();

    alu_serial_issue #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
    alu_serial_issue #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    alu_serial_issue #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    int passed = 0;
    int total  = 0;

    logic [15:0] r;
    logic        fc, fv, fz, fl, fe;
    int          lat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic valid_of(input int w);
        case (w)
            4:       return if4.out_valid;
            8:       return if8.out_valid;
            default: return if16.out_valid;
        endcase
    endfunction

    // Issue one op, scramble operands after accept, measure latency, optionally consume
    task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] op, input bit consume);
        case (w)
            4:  begin if4.in_a = a[3:0];  if4.in_b = b[3:0];  if4.in_opt = op;  if4.in_valid = 1'b1;  end
            8:  begin if8.in_a = a[7:0];  if8.in_b = b[7:0];  if8.in_opt = op;  if8.in_valid = 1'b1;  end
            default: begin if16.in_a = a; if16.in_b = b; if16.in_opt = op; if16.in_valid = 1'b1; end
        endcase
        @(posedge clk); #1;
        case (w)
            4:  begin if4.in_valid = 1'b0;  if4.in_a = ~a[3:0];  if4.in_b = ~b[3:0];  if4.in_opt = ~op;  end
            8:  begin if8.in_valid = 1'b0;  if8.in_a = ~a[7:0];  if8.in_b = ~b[7:0];  if8.in_opt = ~op;  end
            default: begin if16.in_valid = 1'b0; if16.in_a = ~a; if16.in_b = ~b; if16.in_opt = ~op; end
        endcase
        lat = 0;
        while (!valid_of(w) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        case (w)
            4:  begin r = {12'h000, if4.out_result}; fc = if4.out_carry; fv = if4.out_overflow;
                      fz = if4.out_zero; fl = if4.out_less; fe = if4.out_equal; end
            8:  begin r = {8'h00, if8.out_result}; fc = if8.out_carry; fv = if8.out_overflow;
                      fz = if8.out_zero; fl = if8.out_less; fe = if8.out_equal; end
            default: begin r = if16.out_result; fc = if16.out_carry; fv = if16.out_overflow;
                      fz = if16.out_zero; fl = if16.out_less; fe = if16.out_equal; end
        endcase
        if (consume) begin
            case (w)
                4:       if4.out_ready = 1'b1;
                8:       if8.out_ready = 1'b1;
                default: if16.out_ready = 1'b1;
            endcase
            @(posedge clk); #1;
            if4.out_ready = 1'b0; if8.out_ready = 1'b0; if16.out_ready = 1'b0;
        end
    endtask

    task automatic check_op(input string tag, input logic [15:0] er, input logic ec, input logic ev,
                            input logic ez, input logic el, input logic ee, input int elat);
        check({tag, "_res"},   32'(r),   32'(er));
        check({tag, "_carry"}, 32'(fc),  32'(ec));
        check({tag, "_ovf"},   32'(fv),  32'(ev));
        check({tag, "_zero"},  32'(fz),  32'(ez));
        check({tag, "_less"},  32'(fl),  32'(el));
        check({tag, "_equal"}, 32'(fe),  32'(ee));
        check({tag, "_lat"},   32'(lat), 32'(elat));
    endtask

    initial begin
        if4.in_valid = 0;  if4.in_a = '0;  if4.in_b = '0;  if4.in_opt = '0;  if4.out_ready = 0;
        if8.in_valid = 0;  if8.in_a = '0;  if8.in_b = '0;  if8.in_opt = '0;  if8.out_ready = 0;
        if16.in_valid = 0; if16.in_a = '0; if16.in_b = '0; if16.in_opt = '0; if16.out_ready = 0;

        // Reset state
        #12;
        check("rst_in_ready",  32'(if8.in_ready),  1);
        check("rst_out_valid", 32'(if8.out_valid), 0);
        check("rst_result",    32'(if8.out_result), 0);
        check("rst_flags", 32'({if8.out_carry, if8.out_overflow, if8.out_zero, if8.out_less, if8.out_equal}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // out_ready while idle has no effect
        if8.out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("idle_ready_in_ready",  32'(if8.in_ready),  1);
        check("idle_ready_out_valid", 32'(if8.out_valid), 0);
        if8.out_ready = 1'b0;

        // WIDTH=8 directed vectors
        run_op(8, 16'h7F, 16'h01, 3'b000, 1); check_op("add7f01",  16'h80, 0, 1, 0, 0, 0, 2);
        run_op(8, 16'h00, 16'h01, 3'b001, 1); check_op("sub0001",  16'hFF, 0, 0, 0, 0, 0, 2);
        run_op(8, 16'h05, 16'h05, 3'b001, 1); check_op("sub0505",  16'h00, 1, 0, 1, 0, 0, 2);
        run_op(8, 16'h80, 16'h01, 3'b110, 1); check_op("less8001", 16'h7F, 1, 1, 0, 1, 0, 2);
        run_op(8, 16'h05, 16'hFB, 3'b110, 1); check_op("less05fb", 16'h0A, 0, 0, 0, 0, 0, 2);
        run_op(8, 16'h7F, 16'h80, 3'b110, 1); check_op("less7f80", 16'hFF, 0, 1, 0, 0, 0, 2);
        run_op(8, 16'h3C, 16'h3C, 3'b111, 1); check_op("eq3c3c",   16'h00, 1, 0, 0, 0, 1, 2);
        run_op(8, 16'h3C, 16'h00, 3'b010, 1); check_op("not3c",    16'hC3, 0, 0, 0, 0, 0, 2);
        run_op(8, 16'hF0, 16'h3C, 3'b011, 1); check_op("andf03c",  16'h30, 0, 0, 0, 0, 0, 2);
        run_op(8, 16'h00, 16'h00, 3'b100, 1); check_op("or0000",   16'h00, 0, 0, 1, 0, 0, 2);
        run_op(8, 16'hA5, 16'h5A, 3'b101, 1); check_op("xora55a",  16'hFF, 0, 0, 0, 0, 0, 2);

        // Backpressure: result held, new request ignored
        run_op(8, 16'h12, 16'h34, 3'b000, 0); check_op("bp_add", 16'h46, 0, 0, 0, 0, 0, 2);
        if8.in_valid = 1'b1; if8.in_a = 8'h99; if8.in_b = 8'h11; if8.in_opt = 3'b001;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", 32'(if8.out_valid),  1);
            check("bp_result",    32'(if8.out_result), 32'h46);
            check("bp_in_ready",  32'(if8.in_ready),   0);
        end
        if8.in_valid = 1'b0;
        if8.out_ready = 1'b1;
        @(posedge clk); #1;
        if8.out_ready = 1'b0;
        check("bp_consumed_valid", 32'(if8.out_valid), 0);
        check("bp_consumed_ready", 32'(if8.in_ready),  1);
        @(posedge clk); #1;
        check("bp_no_second_op", 32'(if8.out_valid), 0);

        // Reset one cycle after accept aborts the op
        if8.in_a = 8'h11; if8.in_b = 8'h22; if8.in_opt = 3'b000; if8.in_valid = 1'b1;
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(if8.out_valid),  0);
        check("abort_result",    32'(if8.out_result), 0);
        check("abort_in_ready",  32'(if8.in_ready),   1);
        check("abort_flags", 32'({if8.out_carry, if8.out_overflow, if8.out_zero, if8.out_less, if8.out_equal}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_no_valid", 32'(if8.out_valid), 0);
        run_op(8, 16'h7F, 16'h01, 3'b000, 1); check_op("post_abort_add", 16'h80, 0, 1, 0, 0, 0, 2);

        // ADD set at WIDTH=4 and WIDTH=16
        run_op(4, 16'h0007, 16'h0001, 3'b000, 1);  check_op("w4_add71",      16'h0008, 0, 1, 0, 0, 0, 1);
        run_op(4, 16'h000F, 16'h0001, 3'b000, 1);  check_op("w4_addf1",      16'h0000, 1, 0, 1, 0, 0, 1);
        run_op(16, 16'h7FFF, 16'h0001, 3'b000, 1); check_op("w16_add7fff1",  16'h8000, 0, 1, 0, 0, 0, 4);
        run_op(16, 16'h1234, 16'h1234, 3'b111, 1); check_op("w16_eq",        16'h0000, 1, 0, 0, 0, 1, 4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
